// File: rtl/alu_pkg.sv
// Shared encodings for the bit-serial ALU: operation codes and sequencer states.
package alu_pkg;

    localparam logic [1:0] ALU_AND = 2'b00;
    localparam logic [1:0] ALU_OR  = 2'b01;
    localparam logic [1:0] ALU_ADD = 2'b10;
    localparam logic [1:0] ALU_SLT = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01,
        S_DONE  = 2'b10
    } state_e;

endpackage

// File: rtl/serial_alu_cell.sv
// One-bit combinational ALU slice. b arrives already inverted when required;
// SLT shares the sum path, and the sequencer does the sign fix-up.
module serial_alu_cell
    import alu_pkg::*;
(
    input  logic [1:0] op,
    input  logic       a,
    input  logic       b,
    input  logic       cin,
    output logic       res,
    output logic       cout
);

    // Full adder plus AND/OR result select
    always_comb begin
        cout = (a & b) | (a & cin) | (b & cin);
        case (op)
            ALU_AND: res = a & b;
            ALU_OR:  res = a | b;
            default: res = a ^ b ^ cin;
        endcase
    end

endmodule

// File: rtl/bit_serial_alu_seq.sv
// Bit-serial MIPS ALU sequencer: one bit per clock, LSB first, start/done handshake.
// Optional zero-detect output enabled by defining BIT_SERIAL_ALU_ZERO_EN.
module bit_serial_alu_seq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic             binv,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow,
    output logic             zero
);

    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_sh_q, res_sh_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [1:0]       op_q, op_d;
    logic             binv_q, binv_d;
    logic             carry_q, carry_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic             cell_res, cell_cout;
    logic             accept, shift_last, ovf_n, slt_bit, arith;
    logic             binv_e;
    logic [WIDTH-1:0] assembled;

    serial_alu_cell u_cell (
        .op   (op_q),
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0] ^ binv_q),
        .cin  (carry_q),
        .res  (cell_res),
        .cout (cell_cout)
    );

    assign accept     = (state_q == S_IDLE) && start;
    assign shift_last = (state_q == S_SHIFT) && (cnt_q == LastCnt);
    assign ovf_n      = carry_q ^ cell_cout;
    assign slt_bit    = cell_res ^ ovf_n;
    assign arith      = op_q[1];
    assign binv_e     = (op == ALU_SLT) ? 1'b1 : binv;
    assign assembled  = {cell_res, res_sh_q[WIDTH-1:1]};

    // Sequencer next-state: accept, shift one bit per edge, capture at the MSB
    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_sh_d = res_sh_q;
        result_d = result_q;
        op_d     = op_q;
        binv_d   = binv_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_sh_d   = a;
                    b_sh_d   = b;
                    res_sh_d = '0;
                    op_d     = op;
                    binv_d   = binv_e;
                    carry_d  = op[1] & binv_e;
                    cnt_d    = '0;
                    state_d  = S_SHIFT;
                end
            end
            S_SHIFT: begin
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                res_sh_d = assembled;
                carry_d  = cell_cout;
                cnt_d    = cnt_q + CntW'(1);
                if (cnt_q == LastCnt) begin
                    cout_d   = arith & cell_cout;
                    ovf_d    = arith & ovf_n;
                    result_d = (op_q == ALU_SLT) ? {{(WIDTH-1){1'b0}}, slt_bit} : assembled;
                    state_d  = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Sequencer state and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_sh_q <= '0;
            result_q <= '0;
            op_q     <= ALU_AND;
            binv_q   <= 1'b0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_sh_q <= res_sh_d;
            result_q <= result_d;
            op_q     <= op_d;
            binv_q   <= binv_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

`ifdef BIT_SERIAL_ALU_ZERO_EN
    logic acc_q, acc_d;
    logic zero_q, zero_d;

    // Zero detect: OR every result bit as it is produced, publish at completion
    always_comb begin
        acc_d  = acc_q;
        zero_d = zero_q;
        if (accept) begin
            acc_d = 1'b0;
        end else if (state_q == S_SHIFT) begin
            acc_d = acc_q | cell_res;
        end
        if (shift_last) begin
            zero_d = (op_q == ALU_SLT) ? ~slt_bit : ~(acc_q | cell_res);
        end
    end

    // Zero-detect registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= 1'b0;
            zero_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            zero_q <= zero_d;
        end
    end

    assign zero = zero_q;
`else
    assign zero = 1'b0;
`endif

    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);
    assign result   = result_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_bit_serial_alu_seq.sv
// Directed, table-driven bench for bit_serial_alu_seq (WIDTH=32).
module tb_bit_serial_alu_seq;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic         binv = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, cout, overflow, zero;
    logic [W-1:0] result;

    int checks = 0;
    int errors = 0;

    bit_serial_alu_seq #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op       (op),
        .binv     (binv),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .cout     (cout),
        .overflow (overflow),
        .zero     (zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic [1:0]   op;
        logic         binv;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         cout;
        logic         ovf;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic exp_zero(input logic [1:0] o, input logic [W-1:0] r);
`ifdef BIT_SERIAL_ALU_ZERO_EN
        return (o == 2'b11) ? ~r[0] : (r == '0);
`else
        return 1'b0;
`endif
    endfunction

    // Issue one operation; returns edges from accept to done (0 if never seen).
    task automatic do_op(input logic [1:0] o, input logic bv, input logic [W-1:0] av,
                         input logic [W-1:0] bval, output int lat);
        @(negedge clk);
        op = o; binv = bv; a = av; b = bval; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_accept", W'(busy), W'(1));
        // operands changing after acceptance must not matter
        a = ~av; b = ~bval; binv = ~bv; op = ~o;
        lat = 0;
        while (!done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!done) lat = 0;
    endtask

    int lat;
    int dones;
    logic [W-1:0] prev;

    initial begin
        tbl[0] = '{"add_5_3",     2'b10, 1'b0, 32'h5,         32'h3,         32'h8,         1'b0, 1'b0};
        tbl[1] = '{"sub_min_1",   2'b10, 1'b1, 32'h8000_0000, 32'h1,         32'h7FFF_FFFF, 1'b1, 1'b1};
        tbl[2] = '{"slt_ovf",     2'b11, 1'b0, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h0,         1'b0, 1'b1};
        tbl[3] = '{"slt_m1_1",    2'b11, 1'b0, 32'hFFFF_FFFF, 32'h1,         32'h1,         1'b1, 1'b0};
        tbl[4] = '{"add_wrap",    2'b10, 1'b0, 32'hFFFF_FFFF, 32'h1,         32'h0,         1'b1, 1'b0};
        tbl[5] = '{"sub_eq",      2'b10, 1'b1, 32'h5,         32'h5,         32'h0,         1'b1, 1'b0};
        tbl[6] = '{"and",         2'b00, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1'b0};
        tbl[7] = '{"and_binv",    2'b00, 1'b1, 32'hFFFF_FFFF, 32'h0000_FFFF, 32'hFFFF_0000, 1'b0, 1'b0};
        tbl[8] = '{"or_binv",     2'b01, 1'b1, 32'h0,         32'hFFFF_0000, 32'h0000_FFFF, 1'b0, 1'b0};

        // Reset state
        #2;
        chk("rst_busy", W'(busy), W'(0));
        chk("rst_done", W'(done), W'(0));
        chk("rst_result", result, '0);
        chk("rst_cout_ovf_zero", W'({cout, overflow, zero}), W'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven vectors
        for (int i = 0; i < 9; i++) begin
            do_op(tbl[i].op, tbl[i].binv, tbl[i].a, tbl[i].b, lat);
            chk({tbl[i].name, "_latency"}, W'(lat), W'(W));
            chk({tbl[i].name, "_result"}, result, tbl[i].res);
            chk({tbl[i].name, "_cout"}, W'(cout), W'(tbl[i].cout));
            chk({tbl[i].name, "_ovf"}, W'(overflow), W'(tbl[i].ovf));
            chk({tbl[i].name, "_zero"}, W'(zero), W'(exp_zero(tbl[i].op, tbl[i].res)));
            chk({tbl[i].name, "_busy_in_done"}, W'(busy), W'(1));
            @(posedge clk); #1;
            chk({tbl[i].name, "_done_pulse"}, W'({done, busy}), W'(0));
            chk({tbl[i].name, "_result_hold"}, result, tbl[i].res);
        end
        prev = tbl[8].res;

        // start while busy (cycle 10) and start during DONE are both ignored
        @(negedge clk);
        op = 2'b00; binv = 1'b0; a = 32'hF0F0_F0F0; b = 32'hFF00_FF00; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        dones = 0;
        for (int cyc = 1; cyc <= 80; cyc++) begin
            @(posedge clk); #1;
            if (cyc == 5) chk("hold_prev_result", result, prev);
            if (cyc == 9) begin
                start = 1'b1; op = 2'b01; binv = 1'b1; a = '0; b = 32'h1234_5678;
            end
            if (cyc == 10) start = 1'b0;
            if (done) begin
                dones++;
                chk("busy_start_latency", W'(cyc), W'(W));
                chk("busy_start_result", result, 32'hF000_F000);
                start = 1'b1;
            end
            if (cyc == 33) begin
                start = 1'b0;
                chk("start_in_done_ignored", W'(busy), W'(0));
            end
        end
        chk("busy_start_done_count", W'(dones), W'(1));

        // Asynchronous reset mid-ADD aborts with no done
        @(negedge clk);
        op = 2'b10; binv = 1'b0; a = 32'h7; b = 32'h9; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int cyc = 1; cyc <= 15; cyc++) begin
            @(posedge clk);
        end
        #3;
        rst_n = 1'b0;
        #1;
        chk("abort_busy_done", W'({busy, done}), W'(0));
        chk("abort_result", result, '0);
        chk("abort_flags", W'({cout, overflow, zero}), W'(0));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(posedge clk); #1;
            if (done || busy) dones++;
        end
        chk("abort_no_done", W'(dones), W'(0));

        do_op(2'b10, 1'b0, 32'h7, 32'h9, lat);
        chk("post_reset_latency", W'(lat), W'(W));
        chk("post_reset_result", result, 32'h10);
        chk("post_reset_flags", W'({cout, overflow}), W'(0));
        @(posedge clk); #1;
        chk("post_reset_idle", W'({done, busy}), W'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
